double_value_decoder: RTL

- Receive-side inverse of the doubling scaler: recovers original operands from a stream of scaled words, out = in >> SHIFT.
- Flags words that are not exact multiples of 2**SHIFT, counts those errors and buffers decoded results in a small FIFO.
- Uses valid/ready handshakes on both sides.
- Sits between the scaled-data producer and downstream consumers that need the original values.

---
 rtl/dvd_pkg.sv | 32 +++
 rtl/dvd_sync_fifo.sv | 56 +++++
 rtl/double_value_decoder.sv | 59 +++++
 3 files changed

// File: rtl/dvd_pkg.sv
// Shared types and the decode helper for the scaled-word decoder.
package dvd_pkg;
  localparam int DVD_WIDTH = 8;
  localparam int DVD_DEPTH = 4;
  localparam int PTR_W     = $clog2(DVD_DEPTH);
  localparam int OCC_W     = PTR_W + 1;
  // Widest word the decode helper handles; instances zero-extend into it.
  localparam int DVD_MAX_W = 64;

  typedef struct packed {
    logic                 err;
    logic [DVD_WIDTH-1:0] data;
  } dvd_entry_t;

  typedef struct packed {
    logic                 err;
    logic [DVD_MAX_W-1:0] data;
  } dvd_dec_t;

  typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_state_e;

  // Undo the 2**shift scaling: logical right shift, flag any dropped ones.
  function automatic dvd_dec_t dvd_decode(input logic [DVD_MAX_W-1:0] word,
                                          input int unsigned shift);
    dvd_dec_t             r;
    logic [DVD_MAX_W-1:0] mask;
    mask   = (DVD_MAX_W'(1) << shift) - DVD_MAX_W'(1);
    r.err  = |(word & mask);
    r.data = word >> shift;
    return r;
  endfunction
endpackage

// File: rtl/dvd_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head is read straight from storage.
module dvd_sync_fifo
  import dvd_pkg::*;
#(
  parameter int W     = DVD_WIDTH + 1,
  parameter int DEPTH = DVD_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output occ_state_e   state
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   occ;
  logic          full, empty, do_push, do_pop;

  assign full    = (state == OCC_FULL);
  assign empty   = (state == OCC_EMPTY);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Empty FIFO presents zeros rather than stale storage.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Classify occupancy into empty / partial / full.
  always_comb begin
    state = OCC_PARTIAL;
    if (occ == '0)                    state = OCC_EMPTY;
    else if (occ == (PW+1)'(DEPTH))   state = OCC_FULL;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + (PW+1)'(1);
        2'b01:   occ <= occ - (PW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: rtl/double_value_decoder.sv
// Recovers original operands from doubled/scaled words, flags inexact words,
// counts them and queues decoded results for the downstream consumer.
module double_value_decoder
  import dvd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_dec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  input  logic             clr_err,
  output logic [CNT_W-1:0] err_count
);
  dvd_dec_t   dec;
  occ_state_e fifo_state;
  logic       accept, push, pop;
  logic [WIDTH:0] rd_entry;
  logic       dec_unused;

  assign dec        = dvd_decode(DVD_MAX_W'(in_data), SHIFT);
  assign dec_unused = ^dec.data[DVD_MAX_W-1:WIDTH];

  // With decode disabled words are swallowed, so backpressure only applies when enqueuing.
  assign in_ready  = ~enable_dec | (fifo_state != OCC_FULL);
  assign accept    = in_valid & in_ready;
  assign push      = accept & enable_dec;
  assign out_valid = (fifo_state != OCC_EMPTY);
  assign pop       = out_valid & out_ready;
  assign out_err   = rd_entry[WIDTH];
  assign out_data  = rd_entry[WIDTH-1:0];

  dvd_sync_fifo #(.W(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({dec.err, dec.data[WIDTH-1:0]}),
    .rdata (rd_entry),
    .state (fifo_state)
  );

  // Saturating error counter; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst)          err_count <= '0;
    else if (clr_err) err_count <= '0;
    else if (push && dec.err && (err_count != '1))
      err_count <= err_count + CNT_W'(1);
  end
endmodule
